// File: rtl/ram_rr_arbiter_if.sv
// Client/RAM bus bundle for ram_rr_arbiter: two request/response ports plus the RAM port.
// The slave modport is the arbiter's view; master is the client/RAM side.
interface ram_rr_arbiter_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [AWIDTH-1:0] req0_addr;
    logic [DWIDTH-1:0] req0_din;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [AWIDTH-1:0] req1_addr;
    logic [DWIDTH-1:0] req1_din;
    logic              rsp0_valid;
    logic [DWIDTH-1:0] rsp0_dout;
    logic              rsp1_valid;
    logic [DWIDTH-1:0] rsp1_dout;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_din,
        input  req1_valid, req1_we, req1_addr, req1_din,
        input  ram_dout,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_dout, rsp1_valid, rsp1_dout,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_din,
        output req1_valid, req1_we, req1_addr, req1_din,
        output ram_dout,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_dout, rsp1_valid, rsp1_dout,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin two-requester front end for a single-port sync-read RAM, 2-cycle read latency.
// Optional post-reset clear sweep enabled by defining RAM_ARB_INIT_CLEAR_EN.
module ram_rr_arbiter #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_rr_arbiter_if.slave   bus,
    output logic              init_done
);
    logic              w_run;
    logic              w_init_we;
    logic [AWIDTH-1:0] w_init_addr;

`ifdef RAM_ARB_INIT_CLEAR_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t            r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_clr_cnt, w_clr_cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        if (r_state == ST_INIT) begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == {AWIDTH{1'b1}}) begin
                w_state_nxt   = ST_RUN;
                w_clr_cnt_nxt = '0;
            end
        end
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_init_we   = (r_state == ST_INIT);
    assign w_init_addr = r_clr_cnt;
`else
    assign w_run       = 1'b1;
    assign w_init_we   = 1'b0;
    assign w_init_addr = '0;
`endif

    logic              r_last_grant;
    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_sel_we;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_din;

    // On a tie the requester that did not win the last transfer gets the slot.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (w_run) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last_grant;
            end else if (bus.req0_valid) begin
                w_gnt_vld = 1'b1;
            end else if (bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end
    end

    assign w_sel_we   = w_gnt_id ? bus.req1_we   : bus.req0_we;
    assign w_sel_addr = w_gnt_id ? bus.req1_addr : bus.req0_addr;
    assign w_sel_din  = w_gnt_id ? bus.req1_din  : bus.req0_din;

    assign bus.req0_ready = reset_n && w_gnt_vld && !w_gnt_id;
    assign bus.req1_ready = reset_n && w_gnt_vld &&  w_gnt_id;

    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (w_init_we) begin
            bus.ram_we   = 1'b1;
            bus.ram_addr = w_init_addr;
        end else if (w_gnt_vld) begin
            bus.ram_we   = w_sel_we;
            bus.ram_addr = w_sel_addr;
            bus.ram_din  = w_sel_din;
        end
        if (!reset_n) begin
            bus.ram_we = 1'b0;
        end
    end

    logic              r_pend_vld;
    logic              r_pend_id;
    logic              r_rsp0_vld;
    logic              r_rsp1_vld;
    logic [DWIDTH-1:0] r_rsp0_dout;
    logic [DWIDTH-1:0] r_rsp1_dout;

    // RAM dout is valid the cycle after the address edge, so capture one cycle after the read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_pend_vld   <= 1'b0;
            r_pend_id    <= 1'b0;
            r_rsp0_vld   <= 1'b0;
            r_rsp1_vld   <= 1'b0;
            r_rsp0_dout  <= '0;
            r_rsp1_dout  <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_last_grant <= w_gnt_id;
            end
            r_pend_vld <= w_gnt_vld && !w_sel_we;
            r_pend_id  <= w_gnt_id;
            r_rsp0_vld <= r_pend_vld && !r_pend_id;
            r_rsp1_vld <= r_pend_vld &&  r_pend_id;
            if (r_pend_vld && !r_pend_id) begin
                r_rsp0_dout <= bus.ram_dout;
            end
            if (r_pend_vld && r_pend_id) begin
                r_rsp1_dout <= bus.ram_dout;
            end
        end
    end

    assign bus.rsp0_valid = r_rsp0_vld;
    assign bus.rsp1_valid = r_rsp1_vld;
    assign bus.rsp0_dout  = r_rsp0_dout;
    assign bus.rsp1_dout  = r_rsp1_dout;
    assign init_done      = w_run;
endmodule

// File: doc/ram_rr_arbiter.md
# ram_rr_arbiter

Two-requester controller sharing one single-port synchronous-read RAM (registered read address, data valid the cycle after the address edge). Arbitrates read/write requests round-robin with a valid/ready handshake and returns read data at a fixed two-cycle latency. Optionally clears the whole array after reset before accepting traffic. Sits between two client engines and the RAM instance.

## Interface

- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH
- DWIDTH, 32, data width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid && ready = transfer)
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AWIDTH  request address
- req0_din / req1_din  in  DWIDTH  write data
- rsp0_valid / rsp1_valid  out  1  read data valid (one-cycle pulse per read)
- rsp0_dout / rsp1_dout  out  DWIDTH  read data, registered
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  DWIDTH  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DWIDTH  from RAM dout
- init_done  out  1  high once controller is in RUN

## Operation

- States: INIT (clear sweep), RUN. Reset enters INIT (RUN if macro absent).
- INIT: counter clr_cnt 0..DEPTH-1; each cycle ram_we=1, ram_addr=clr_cnt, ram_din=0; both req_ready=0. After writing DEPTH-1, next state RUN. Exactly DEPTH cycles.
- RUN arbitration (combinational): only one valid -> that one granted; both valid -> grant requester != last_grant; none -> no grant. reqK_ready = (state==RUN) && grant==K; never both high.
- last_grant register, reset 1 (requester 0 wins the first tie); updates only on a transfer.
- Transfer drives ram_addr/ram_din/ram_we from granted requester same cycle (combinational mux). No transfer: ram_we=0, ram_addr=0, ram_din=0.
- Write: no response.
- Read: stage-1 flag rd_pend (valid + requester id) set at end of transfer cycle N; at end of N+1, rspK_dout <= ram_dout, rspK_valid <= 1 for the tagged requester, other rsp_valid 0. rsp_dout holds last value when rsp_valid low.
- Clients must accept responses unconditionally (no response backpressure).
- Write then read of same address on consecutive cycles returns new data (RAM is write-first via latched address); controller adds no forwarding.
- Full throughput: one transfer per cycle, back-to-back reads from either requester pipeline without bubbles.

## Timing

- Reset (reset_n low, async): state INIT (or RUN), clr_cnt=0, last_grant=1, rd_pend clear, rsp0/1_valid=0, rsp0/1_dout=0, init_done=0 (1 without macro); req0/1_ready forced 0 and ram_we forced 0 while reset_n low.
- Read latency: transfer in cycle N -> rspK_valid high in cycle N+2.
- init_done rises in the first RUN cycle (DEPTH cycles after reset release with macro).
- Reset mid-operation: in-flight reads are dropped (no rsp_valid after reset release); INIT restarts from address 0.
- Requester may change valid/addr freely while ready low; no transfer occurs.

## Configuration

- RAM_ARB_INIT_CLEAR_EN defined: INIT state and clr_cnt present; array zeroed after every reset; init_done low for DEPTH cycles after reset release.
- Not defined: INIT and clr_cnt removed; controller resets into RUN; init_done is 1 out of reset; RAM contents untouched (file-initialised contents preserved).

## Test plan

- Macro on, release reset, then req0 read addr 5 at first ready -> ram_we=1 for exactly 8 cycles (addr 0..7, din 0), init_done rises cycle 9, rsp0_dout=0 two cycles after transfer.
- req0 write addr 3 = 0xDEADBEEF, next cycle req0 read addr 3 -> rsp0_valid pulse with 0xDEADBEEF two cycles after read transfer.
- Both requesters hold valid reading addr 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_valid alternates rsp0/rsp1 with matching data, one per cycle.
- Only req1 valid for 4 cycles -> req1_ready high all 4 cycles; then both valid -> req0 granted first.
- Read issued, reset_n pulsed low in cycle N+1 -> no rsp_valid afterwards; INIT sweep restarts at addr 0.
- Macro off, file-initialised RAM, read addr 7 in first cycle after reset -> preloaded value returned at N+2, init_done=1 throughout.
